imem_loader: RTL and testbench
==============================

// Module: imem_loader
//
// PURPOSE
//   Write side of the single-cycle CPU instruction memory. Receives a program as a byte
//   stream over a valid/ready handshake and packs the bytes into 32-bit little-endian words.
//   Writes each word into the instruction RAM at byte addresses 0, 4, 8, ...
//   Holds the CPU in reset until the whole image is written, then releases it.
//
// PARAMETERS
//   ADDR_W     10    instruction memory address width; byte address, word-aligned
//   DATA_W     32    instruction word width; must equal 4*8
//   MAX_WORDS  256   largest accepted image, equal to 2**ADDR_W/4
//
// PORTS
//   clock        in   1       single clock; all state updates on its rising edge
//   reset_n      in   1       asynchronous, active-low reset
//   start        in   1       1-cycle pulse; begins, or restarts, a load
//   byte_in      in   8       stream byte
//   byte_valid   in   1       byte_in is valid
//   byte_ready   out  1       loader accepts byte_in this cycle
//   mem_we       out  1       instruction RAM write enable, 1-cycle pulse
//   mem_addr     out  ADDR_W  RAM byte address, always a multiple of 4
//   mem_wdata    out  DATA_W  RAM write data
//   busy         out  1       load in progress
//   done         out  1       image fully written; sticky until start or reset
//   error        out  1       image length > MAX_WORDS; sticky until start or reset
//   cpu_reset_n  out  1       CPU reset, active low; 1 only while done=1
//
// BEHAVIOUR
//   - Reset (async, reset_n=0): state IDLE.
//     All outputs are 0, including cpu_reset_n, so the CPU stays held.
//     Internal count and address registers clear to 0.
//   - Handshake: a byte transfers when byte_valid & byte_ready at a rising edge.
//     byte_ready = (state in HDR0/HDR1/DATA) & ~start. It is combinational from state and start.
//   - Stream format: 2 header bytes carry the 16-bit word count N, low byte first.
//     N*4 data bytes follow. Each word is little-endian: the first byte goes to bits [7:0].
//   - States and transitions:
//       IDLE : start -> HDR0
//       HDR0 : byte transferred -> latch N[7:0]; go to HDR1
//       HDR1 : byte transferred -> latch N[15:8]
//              N==0 -> DONE; N>MAX_WORDS -> ERR; otherwise -> DATA
//       DATA : on each transferred byte, increment byte index 0..3
//              at index 3, word complete: load mem_wdata, set the write-pending flag, index -> 0
//              after the N-th word's write pulse -> DONE
//       DONE : done=1, cpu_reset_n=1, busy=0; start -> HDR0
//       ERR  : error=1, busy=0, cpu_reset_n=0; start -> HDR0
//   - busy=1 in HDR0, HDR1 and DATA.
//   - start in any state restarts: go to HDR0; clear the byte index, word count and address;
//     clear done and error; drive cpu_reset_n=0 from the next cycle.
//     A word already written stays in the RAM.
//   - Write timing: mem_we pulses for exactly one cycle, in the cycle after the word's 4th byte
//     transfers, with mem_addr = 4*k for word k (0-based).
//     mem_addr increments by 4 after the pulse, modulo 2**ADDR_W.
//     Wrap-around is unreachable because N <= MAX_WORDS.
//     byte_ready stays 1 during the pulse; back-to-back bytes at full rate are legal.
//     Peak rate is 1 word per 4 cycles.
//   - DONE is entered in the cycle after the last mem_we pulse.
//     done and cpu_reset_n rise together, so the CPU never fetches a partially written image.
//   - mem_wdata and mem_addr hold their values when mem_we=0.
//   - Bytes presented in IDLE, DONE or ERR are not accepted (byte_ready=0).
//   - A stall (byte_valid=0) in any loading state holds all state. No timeout.
//   - Reset mid-load: immediate return to IDLE. Words already written stay in the RAM.
//
// STRUCTURE
//   - Package imem_loader_pkg contains:
//       the state enum (IDLE, HDR0, HDR1, DATA, DONE, ERR);
//       the constants WORD_BYTES=4 and ADDR_STEP=4.
//   - Sub-module byte_packer (clock, reset_n, clear, push, byte_in -> word, word_ok):
//       2-bit index plus a 32-bit packing register;
//       word_ok pulses when the 4th byte is pushed.
//   - The top level contains the FSM, the word counter, the address counter and the output registers.
//
// TESTING
//   1. Reset: hold reset_n=0 with clock running
//      -> all outputs 0, byte_ready=0.
//      Release reset_n, then pulse start -> byte_ready=1 the next cycle.
//   2. Full-rate load, N=5; words e0810002, e0413000, e2033010, e1833001, eafffffb;
//      first bytes 05 00 02 00 81 e0
//      -> 5 mem_we pulses at addresses 0, 4, 8, 12, 16 with exactly those data values;
//      -> done=1 and cpu_reset_n=1 one cycle after the 5th pulse.
//   3. The same image with byte_valid toggling 1,0,1,0
//      -> identical writes; mem_we never pulses without a completed word.
//   4. Header N=0 -> DONE right after HDR1, with no mem_we pulse.
//      Header N=257 (01 01) -> error=1, cpu_reset_n=0, no writes.
//      Then start -> error=0, busy=1.
//   5. Abort: start after 2 of 3 words
//      -> restart at address 0; the next image's first write goes to address 0.
//      start together with byte_valid=1 -> byte_ready=0 and the byte is not consumed.
//   6. Assert reset_n=0 mid-DATA with no clock edge
//      -> all outputs 0 immediately, including cpu_reset_n; state IDLE after release.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory loader.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HDR0,
    HDR1,
    DATA,
    DONE,
    ERR
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_STEP  = 4;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream handshake plus instruction-RAM write port of the loader.
interface imem_loader_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);

  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  // Host side: sources the byte stream, observes the RAM writes.
  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );

  // Loader side.
  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_loader_byte_packer.sv
// Packs four stream bytes into one little-endian word; the first byte lands in [7:0].
module byte_packer
  import imem_loader_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              push,
  input  logic [7:0]        byte_in,
  output logic [DATA_W-1:0] word,
  output logic              word_ok
);

  logic [1:0]        idx;
  logic [DATA_W-9:0] pack;

  // Byte lane index within the current word, wraps after the last lane.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx <= 2'd0;
    end else if (clear) begin
      idx <= 2'd0;
    end else if (push) begin
      idx <= idx + 2'd1;
    end
  end

  // Lower three lanes are buffered; the top lane is taken straight from byte_in.
  always_ff @(posedge clock) begin
    if (push) begin
      case (idx)
        2'd0:    pack[7:0]   <= byte_in;
        2'd1:    pack[15:8]  <= byte_in;
        2'd2:    pack[23:16] <= byte_in;
        default: ;
      endcase
    end
  end

  assign word    = {byte_in, pack};
  assign word_ok = push && (idx == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Loads a length-prefixed byte stream into the CPU instruction RAM and
// holds the CPU in reset until the complete image has been written.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 32,
  parameter int MAX_WORDS = 256
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         cpu_reset_n
);

  localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

  state_t            state;
  state_t            state_nxt;
  logic              loading;
  logic              ready;
  logic              xfer;
  logic              push;
  logic [7:0]        n_lo;
  logic [15:0]       n_hdr;
  logic [15:0]       n_words;
  logic [15:0]       w_cnt;
  logic [ADDR_W-1:0] addr_cnt;
  logic              last_word;
  logic [DATA_W-1:0] word;
  logic              word_ok;

  assign loading        = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign ready          = loading && !start;
  assign xfer           = ready && bus.byte_valid;
  assign push           = xfer && (state == DATA);
  assign bus.byte_ready = ready;

  assign n_hdr     = {bus.byte_in, n_lo};
  assign last_word = bus.mem_we && ((w_cnt + 16'd1) == n_words);

  // Status is decoded from state so an async reset clears it at once;
  // cpu_reset_n tracks done so the CPU only runs on a complete image.
  assign busy        = loading;
  assign done        = (state == DONE);
  assign error       = (state == ERR);
  assign cpu_reset_n = done;

  byte_packer #(
    .DATA_W (DATA_W)
  ) u_packer (
    .clock   (clock),
    .reset_n (reset_n),
    .clear   (start),
    .push    (push),
    .byte_in (bus.byte_in),
    .word    (word),
    .word_ok (word_ok)
  );

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; start overrides every state and restarts the load.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: ;
      HDR0: begin
        if (xfer) state_nxt = HDR1;
      end
      HDR1: begin
        if (xfer) begin
          if (n_hdr == 16'd0)      state_nxt = DONE;
          else if (n_hdr > MAX_N)  state_nxt = ERR;
          else                     state_nxt = DATA;
        end
      end
      DATA: begin
        if (last_word) state_nxt = DONE;
      end
      DONE: ;
      ERR:  ;
      default: state_nxt = IDLE;
    endcase
    if (start) state_nxt = HDR0;
  end

  // Header capture: low byte is buffered until the high byte arrives.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      n_lo    <= 8'd0;
      n_words <= 16'd0;
    end else if (start) begin
      n_lo    <= 8'd0;
      n_words <= 16'd0;
    end else if (xfer && (state == HDR0)) begin
      n_lo <= bus.byte_in;
    end else if (xfer && (state == HDR1)) begin
      n_words <= n_hdr;
    end
  end

  // Written-word count and next write address advance after each pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      w_cnt    <= 16'd0;
      addr_cnt <= '0;
    end else if (start) begin
      w_cnt    <= 16'd0;
      addr_cnt <= '0;
    end else if (bus.mem_we) begin
      w_cnt    <= w_cnt + 16'd1;
      addr_cnt <= addr_cnt + ADDR_W'(ADDR_STEP);
    end
  end

  // RAM write port: one-cycle pulse after the 4th byte, address/data hold otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      bus.mem_we <= word_ok;
      if (word_ok) begin
        bus.mem_addr  <= addr_cnt;
        bus.mem_wdata <= word;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued as bytes
// are driven and matched against every mem_we pulse.
module tb_imem_loader;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } exp_t;

  logic clock;
  logic reset_n;
  logic start;
  logic busy, done, error, cpu_reset_n;

  imem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_loader #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_WORDS (256)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .start       (start),
    .bus         (bus.slave),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_reset_n (cpu_reset_n)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];
  exp_t mon_e;
  logic [31:0] img[$];

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Every write pulse must match the oldest queued expectation.
  always @(negedge clock) begin
    if (bus.mem_we === 1'b1) begin
      if (sb.size() == 0) begin
        check_val("we_unexpected", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("wr_addr", bus.mem_addr, mon_e.addr);
        check_val("wr_data", bus.mem_wdata, mon_e.data);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Caller is at posedge+1; returns at posedge+1 after the transfer edge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    if (gap) begin
      bus.byte_valid = 1'b0;
      @(posedge clock); #1;
    end
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    n = 0;
    @(negedge clock);
    while (bus.byte_ready !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    if (n >= 50) check_val("ready_timeout", 0, 1);
    @(posedge clock); #1;
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input int k, input logic [31:0] w, input bit gap);
    for (int b = 0; b < 4; b++) begin
      if (b == 3) sb.push_back(exp_t'{ADDR_W'(k * 4), w});
      send_byte(w[8*b +: 8], gap);
    end
  endtask

  task automatic send_image(input logic [31:0] words[$], input bit gap);
    logic [15:0] n;
    n = 16'(words.size());
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
    for (int k = 0; k < words.size(); k++) send_word(k, words[k], gap);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
  endtask

  // After the last data byte: pulse cycle, then done/cpu_reset_n together.
  task automatic check_finish(input string tag);
    @(negedge clock);
    check_val({tag, "_done_in_pulse"}, done, 0);
    @(negedge clock);
    check_val({tag, "_done"}, done, 1);
    check_val({tag, "_cpu_rst_n"}, cpu_reset_n, 1);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_sb_empty"}, sb.size(), 0);
    @(posedge clock); #1;
  endtask

  initial begin
    reset_n        = 1'b0;
    start          = 1'b0;
    bus.byte_in    = 8'h00;
    bus.byte_valid = 1'b0;

    // 1. Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_val("rst_byte_ready", bus.byte_ready, 0);
    check_val("rst_mem_we", bus.mem_we, 0);
    check_val("rst_mem_addr", bus.mem_addr, 0);
    check_val("rst_mem_wdata", bus.mem_wdata, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_error", error, 0);
    check_val("rst_cpu_rst_n", cpu_reset_n, 0);
    reset_n = 1'b1;
    @(posedge clock); #1;
    pulse_start();
    @(negedge clock);
    check_val("start_ready", bus.byte_ready, 1);
    check_val("start_busy", busy, 1);
    @(posedge clock); #1;

    // 2. Full-rate load
    img = '{32'he0810002, 32'he0413000, 32'he2033010, 32'he1833001, 32'heafffffb};
    send_image(img, 1'b0);
    check_finish("full");

    // 3. Same image with byte_valid toggling
    pulse_start();
    send_image(img, 1'b1);
    check_finish("toggle");

    // 4a. Empty image
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    @(negedge clock);
    check_val("n0_done", done, 1);
    check_val("n0_cpu_rst_n", cpu_reset_n, 1);
    check_val("n0_busy", busy, 0);
    @(posedge clock); #1;

    // 4b. Oversized image (257 words)
    pulse_start();
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    check_val("big_error", error, 1);
    check_val("big_cpu_rst_n", cpu_reset_n, 0);
    check_val("big_busy", busy, 0);
    check_val("big_ready", bus.byte_ready, 0);
    @(posedge clock); #1;
    pulse_start();
    @(negedge clock);
    check_val("restart_error", error, 0);
    check_val("restart_busy", busy, 1);
    @(posedge clock); #1;

    // 5. Abort after 2 of 3 words; start collides with a valid byte
    send_byte(8'h03, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(0, 32'hdeadbeef, 1'b0);
    send_word(1, 32'hcafef00d, 1'b0);
    start          = 1'b1;
    bus.byte_in    = 8'haa;
    bus.byte_valid = 1'b1;
    @(negedge clock);
    check_val("abort_ready", bus.byte_ready, 0);
    @(posedge clock); #1;
    start          = 1'b0;
    bus.byte_valid = 1'b0;
    @(negedge clock);
    check_val("abort_done", done, 0);
    check_val("abort_busy", busy, 1);
    @(posedge clock); #1;
    img = '{32'h11223344};
    send_image(img, 1'b0);
    check_finish("after_abort");

    // 6. Asynchronous reset mid-DATA
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_byte(8'h10, 1'b0);
    send_byte(8'h20, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    check_val("arst_busy", busy, 0);
    check_val("arst_ready", bus.byte_ready, 0);
    check_val("arst_mem_we", bus.mem_we, 0);
    check_val("arst_mem_wdata", bus.mem_wdata, 0);
    check_val("arst_cpu_rst_n", cpu_reset_n, 0);
    check_val("arst_done", done, 0);
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(negedge clock);
    check_val("post_arst_busy", busy, 0);
    check_val("post_arst_ready", bus.byte_ready, 0);
    @(posedge clock); #1;
    pulse_start();
    @(negedge clock);
    check_val("post_arst_start", busy, 1);
    check_val("final_sb_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
